abft_error_locator: RTL and testbench
=====================================

ABFT_ERROR_LOCATOR -- requirements
Module: abft_error_locator

Interface
REQ-001 Parameter arraySize, default 4: systolic array dimension n.
REQ-002 Parameter addressWidth, default 2: width of row/column index, ceil(log2(arraySize)).
REQ-003 Parameter zBits, default 28: width of incoming checksum dot products, two's complement.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 clear  input  1  synchronous; clears sticky overrun flag.
REQ-007 valid_in  input  1  one-cycle qualifier for the four dot products from the checksum dot-product stage.
REQ-008 ae_dot, be_dot, ce_dot, de_dot  input  zBits each  row-ones, row-index-weighted, column-ones and column-index-weighted error sums.
REQ-009 ready  output  1  high only in IDLE.
REQ-010 err_valid  output  1  one-cycle pulse qualifying the result outputs.
REQ-011 err_none, err_single, err_multi  output  1 each  one-hot classification, valid with err_valid.
REQ-012 err_row, err_col  output  addressWidth each  located element indices.
REQ-013 err_mag  output  zBits  signed error magnitude (ae_dot).
REQ-014 overrun  output  1  sticky: valid_in arrived while not ready.

Function
REQ-015 FSM states: IDLE, CHECK, DIV, REPORT; reset state IDLE.
REQ-016 IDLE: on valid_in, register all four dots and go to CHECK; otherwise stay.
REQ-017 CHECK: all four dots zero -> REPORT with err_none; ae_dot==0 or ce_dot==0 (others nonzero) or ae_dot!=ce_dot -> REPORT with err_multi; else start both dividers, go to DIV.
REQ-018 DIV: unsigned restoring division |be|/|ae| and |de|/|ce|, one quotient bit per cycle, exactly zBits cycles, both run in lockstep.
REQ-019 After DIV: err_single only if both remainders zero, sign(be) matches sign(ae) or be==0, sign(de) matches sign(ce) or de==0, and both quotients < arraySize; otherwise err_multi.
REQ-020 REPORT: err_valid high for exactly one cycle, then IDLE; err_row/err_col = quotients truncated to addressWidth when err_single, else 0; err_mag = registered ae_dot.
REQ-021 Latency from valid_in sampling edge to err_valid: 2 cycles for CHECK-resolved cases, zBits+2 cycles for division cases.
REQ-022 Result outputs hold their values until next REPORT; err_valid low elsewhere.
REQ-023 valid_in while not in IDLE is dropped and sets overrun; valid_in in the same cycle as REPORT is dropped.
REQ-024 clear and overrun-set in the same cycle: set wins.
REQ-025 Most-negative zBits input: absolute value taken in zBits+1 bits, no overflow.

Reset
REQ-026 rst low: state IDLE, ready 1 after release, all other outputs and internal registers 0, asynchronously.
REQ-027 rst asserted mid-DIV aborts the division; no err_valid is produced for that input.

Structure
REQ-028 Shared package abft_pkg holds the FSM state enum and the classification encoding.
REQ-029 One sub-module seq_divider (zBits+1-bit unsigned restoring divider with start/done), instantiated twice.
REQ-030 Input capture uses the codebase's dff primitive style registers with the same rst port.

Verification
REQ-031 all dots 0, valid_in one cycle -> err_valid 2 cycles later, err_none=1, row=col=0, mag=0.
REQ-032 ae=5, be=10, ce=5, de=15 -> after 30 cycles err_single, row=2, col=3, mag=5.
REQ-033 ae=-7, be=-21, ce=-7, de=0 -> err_single, row=3, col=0, mag=-7.
REQ-034 ae=5, be=7, ce=5, de=5 (remainder) and ae=5, be=20, ce=5, de=0 (row 4 >= arraySize) and ae=5, ce=6 -> err_multi each.
REQ-035 second valid_in during DIV -> dropped, overrun=1 until clear; first result unaffected.
REQ-036 rst low 10 cycles into DIV -> outputs 0 immediately, no err_valid, ready=1 after release.

Source files
------------

// File: rtl/abft_pkg.sv
// Shared types for the ABFT error locator: controller states and the
// one-hot error classification held in the result register.
package abft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_DIV    = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  // All-zero encoding is the post-reset "no result yet" value.
  typedef enum logic [2:0] {
    CLS_NULL   = 3'b000,
    CLS_NONE   = 3'b001,
    CLS_SINGLE = 3'b010,
    CLS_MULTI  = 3'b100
  } cls_e;

endpackage

// File: rtl/dff.sv
// Enabled register primitive with asynchronous active-low reset to zero.
// Latency 1 cycle; captures only when en is high.
module dff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; the first bit is resolved on the
// start edge so WIDTH bits finish WIDTH-1 cycles later, quot/rem valid combinationally with done.
module seq_divider #(
  parameter int WIDTH = 29
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, qd_q, div_q;
  logic [WIDTH-1:0] src_rem, src_qd, src_div, rem_d, qd_d;
  logic [WIDTH:0]   trial;
  logic             ge;

  // qd_q shifts dividend bits out of the top while quotient bits enter at the bottom.
  always_comb begin
    src_rem = start ? '0       : rem_q;
    src_qd  = start ? dividend : qd_q;
    src_div = start ? divisor  : div_q;
    trial   = {src_rem, src_qd[WIDTH-1]};
    ge      = (trial >= {1'b0, src_div});
    rem_d   = ge ? (trial[WIDTH-1:0] - src_div) : trial[WIDTH-1:0];
    qd_d    = {src_qd[WIDTH-2:0], ge};
  end

  assign done = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign quot = qd_d;
  assign rem  = rem_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      qd_q   <= '0;
      div_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= CW'(1);
      rem_q  <= rem_d;
      qd_q   <= qd_d;
      div_q  <= divisor;
    end else if (busy_q) begin
      rem_q  <= rem_d;
      qd_q   <= qd_d;
      cnt_q  <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/abft_error_locator.sv
// Locates a single corrupted element from row/column checksum dot products.
// Latency 2 cycles (CHECK-resolved) or zBits+2 (division); ready only in IDLE, inputs arriving otherwise are dropped and flagged.
module abft_error_locator
  import abft_pkg::*;
#(
  parameter int arraySize    = 4,
  parameter int addressWidth = 2,
  parameter int zBits        = 28
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    valid_in,
  input  logic [zBits-1:0]        ae_dot,
  input  logic [zBits-1:0]        be_dot,
  input  logic [zBits-1:0]        ce_dot,
  input  logic [zBits-1:0]        de_dot,
  output logic                    ready,
  output logic                    err_valid,
  output logic                    err_none,
  output logic                    err_single,
  output logic                    err_multi,
  output logic [addressWidth-1:0] err_row,
  output logic [addressWidth-1:0] err_col,
  output logic [zBits-1:0]        err_mag,
  output logic                    overrun
);

  localparam int W = zBits + 1;

  state_e                  state_q, state_d;
  cls_e                    cls_q, cls_d;
  logic [addressWidth-1:0] row_q, row_d, col_q, col_d;
  logic [zBits-1:0]        mag_q;
  logic                    overrun_q, overrun_set;
  logic                    cap_en, div_start, div_done, load_res;
  logic [zBits-1:0]        ae_q, be_q, ce_q, de_q;
  logic [W-1:0]            abs_ae, abs_be, abs_ce, abs_de;
  logic [W-1:0]            quot_row, rem_row, quot_col, rem_col;
  logic                    done_row, done_col;
  logic                    all_zero, signs_ok, single_ok;

  // Sign-extending first keeps the most negative input representable after negation.
  function automatic logic [W-1:0] abs_w(input logic [zBits-1:0] x);
    logic [W-1:0] s;
    s = {x[zBits-1], x};
    return x[zBits-1] ? -s : s;
  endfunction

  assign cap_en = (state_q == ST_IDLE) && valid_in;

  dff #(.WIDTH(zBits)) u_ae (.clk(clk), .rst(rst), .en(cap_en), .d(ae_dot), .q(ae_q));
  dff #(.WIDTH(zBits)) u_be (.clk(clk), .rst(rst), .en(cap_en), .d(be_dot), .q(be_q));
  dff #(.WIDTH(zBits)) u_ce (.clk(clk), .rst(rst), .en(cap_en), .d(ce_dot), .q(ce_q));
  dff #(.WIDTH(zBits)) u_de (.clk(clk), .rst(rst), .en(cap_en), .d(de_dot), .q(de_q));

  assign abs_ae = abs_w(ae_q);
  assign abs_be = abs_w(be_q);
  assign abs_ce = abs_w(ce_q);
  assign abs_de = abs_w(de_q);

  seq_divider #(.WIDTH(W)) u_div_row (
    .clk(clk), .rst(rst), .start(div_start), .dividend(abs_be), .divisor(abs_ae),
    .done(done_row), .quot(quot_row), .rem(rem_row)
  );

  seq_divider #(.WIDTH(W)) u_div_col (
    .clk(clk), .rst(rst), .start(div_start), .dividend(abs_de), .divisor(abs_ce),
    .done(done_col), .quot(quot_col), .rem(rem_col)
  );

  assign div_done  = done_row & done_col;
  assign all_zero  = ((ae_q | be_q | ce_q | de_q) == '0);
  assign signs_ok  = ((be_q == '0) || (be_q[zBits-1] == ae_q[zBits-1])) &&
                     ((de_q == '0) || (de_q[zBits-1] == ce_q[zBits-1]));
  assign single_ok = (rem_row == '0) && (rem_col == '0) && signs_ok &&
                     (quot_row < W'(arraySize)) && (quot_col < W'(arraySize));

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    load_res  = 1'b0;
    cls_d     = CLS_MULTI;
    row_d     = '0;
    col_d     = '0;
    case (state_q)
      ST_IDLE: begin
        if (valid_in) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (all_zero) begin
          state_d  = ST_REPORT;
          load_res = 1'b1;
          cls_d    = CLS_NONE;
        end else if ((ae_q == '0) || (ce_q == '0) || (ae_q != ce_q)) begin
          state_d  = ST_REPORT;
          load_res = 1'b1;
        end else begin
          state_d   = ST_DIV;
          div_start = 1'b1;
        end
      end
      ST_DIV: begin
        if (div_done) begin
          state_d  = ST_REPORT;
          load_res = 1'b1;
          if (single_ok) begin
            cls_d = CLS_SINGLE;
            row_d = quot_row[addressWidth-1:0];
            col_d = quot_col[addressWidth-1:0];
          end
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign overrun_set = valid_in && (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cls_q     <= CLS_NULL;
      row_q     <= '0;
      col_q     <= '0;
      mag_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_res) begin
        cls_q <= cls_d;
        row_q <= row_d;
        col_q <= col_d;
        mag_q <= ae_q;
      end
      if (overrun_set)  overrun_q <= 1'b1;
      else if (clear)   overrun_q <= 1'b0;
    end
  end

  assign ready      = (state_q == ST_IDLE);
  assign err_valid  = (state_q == ST_REPORT);
  assign err_none   = (cls_q == CLS_NONE);
  assign err_single = (cls_q == CLS_SINGLE);
  assign err_multi  = (cls_q == CLS_MULTI);
  assign err_row    = row_q;
  assign err_col    = col_q;
  assign err_mag    = mag_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_abft_error_locator.sv
// Scoreboard bench for abft_error_locator: directed vectors push expected results,
// a negedge monitor pops and compares whenever err_valid is seen.
module tb_abft_error_locator;

  localparam int ZB = 28;
  localparam int AW = 2;
  localparam int L_CHK = 2;
  localparam int L_DIV = ZB + 2;
  localparam logic [2:0] C_NONE = 3'b001;
  localparam logic [2:0] C_SGL  = 3'b010;
  localparam logic [2:0] C_MUL  = 3'b100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear = 1'b0;
  logic          valid_in = 1'b0;
  logic [ZB-1:0] ae_dot = '0, be_dot = '0, ce_dot = '0, de_dot = '0;
  logic          ready, err_valid, err_none, err_single, err_multi, overrun;
  logic [AW-1:0] err_row, err_col;
  logic [ZB-1:0] err_mag;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0]    cls;
    logic [AW-1:0] row;
    logic [AW-1:0] col;
    logic [ZB-1:0] mag;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  abft_error_locator #(.arraySize(4), .addressWidth(AW), .zBits(ZB)) dut (
    .clk(clk), .rst(rst), .clear(clear), .valid_in(valid_in),
    .ae_dot(ae_dot), .be_dot(be_dot), .ce_dot(ce_dot), .de_dot(de_dot),
    .ready(ready), .err_valid(err_valid), .err_none(err_none),
    .err_single(err_single), .err_multi(err_multi),
    .err_row(err_row), .err_col(err_col), .err_mag(err_mag), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (err_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_err_valid", 64'(err_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("latency",    64'(cyc),        64'(mon_e.cyc));
        chk("err_none",   64'(err_none),   64'(mon_e.cls[0]));
        chk("err_single", 64'(err_single), 64'(mon_e.cls[1]));
        chk("err_multi",  64'(err_multi),  64'(mon_e.cls[2]));
        chk("err_row",    64'(err_row),    64'(mon_e.row));
        chk("err_col",    64'(err_col),    64'(mon_e.col));
        chk("err_mag",    64'(err_mag),    64'(mon_e.mag));
      end
    end
  end

  task automatic send(input logic [ZB-1:0] a, b, c, d, input logic [2:0] cls,
                      input logic [AW-1:0] r, col, input int lat, input bit expect_out);
    exp_t e;
    @(posedge clk); #1;
    valid_in = 1'b1;
    ae_dot = a; be_dot = b; ce_dot = c; de_dot = d;
    if (expect_out) begin
      e.cls = cls; e.row = r; e.col = col; e.mag = a; e.cyc = cyc + lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    chk("ready_idle", 64'(ready), 64'd1);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",     64'(ready),      64'd1);
    chk("rst_err_valid", 64'(err_valid),  64'd0);
    chk("rst_none",      64'(err_none),   64'd0);
    chk("rst_single",    64'(err_single), 64'd0);
    chk("rst_multi",     64'(err_multi),  64'd0);
    chk("rst_mag",       64'(err_mag),    64'd0);
    chk("rst_overrun",   64'(overrun),    64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(ready), 64'd1);

    // ae, be, ce, de, class, row, col, latency
    send('0, '0, '0, '0,                   C_NONE, 2'd0, 2'd0, L_CHK, 1'b1); drain();
    send(28'd5, 28'd10, 28'd5, 28'd15,     C_SGL,  2'd2, 2'd3, L_DIV, 1'b1); drain();
    send(28'(-7), 28'(-21), 28'(-7), '0,   C_SGL,  2'd3, 2'd0, L_DIV, 1'b1); drain();
    send(28'd5, 28'd7, 28'd5, 28'd5,       C_MUL,  2'd0, 2'd0, L_DIV, 1'b1); drain();
    send(28'd5, 28'd20, 28'd5, '0,         C_MUL,  2'd0, 2'd0, L_DIV, 1'b1); drain();
    send(28'd5, '0, 28'd6, '0,             C_MUL,  2'd0, 2'd0, L_CHK, 1'b1); drain();
    send('0, 28'd3, '0, 28'd3,             C_MUL,  2'd0, 2'd0, L_CHK, 1'b1); drain();
    send(28'd5, 28'd5, '0, '0,             C_MUL,  2'd0, 2'd0, L_CHK, 1'b1); drain();
    send(28'd5, '0, 28'd5, '0,             C_SGL,  2'd0, 2'd0, L_DIV, 1'b1); drain();
    send(28'd5, 28'(-10), 28'd5, 28'd5,    C_MUL,  2'd0, 2'd0, L_DIV, 1'b1); drain();
    send(28'(-7), 28'(-14), 28'(-7), 28'd7, C_MUL, 2'd0, 2'd0, L_DIV, 1'b1); drain();
    send(28'h8000000, '0, 28'h8000000, 28'h8000000, C_SGL, 2'd0, 2'd1, L_DIV, 1'b1); drain();

    // Input arriving mid-division is dropped and flagged until cleared.
    send(28'd5, 28'd10, 28'd5, 28'd15, C_SGL, 2'd2, 2'd3, L_DIV, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    valid_in = 1'b1;
    ae_dot = 28'd1; be_dot = 28'd1; ce_dot = 28'd1; de_dot = 28'd1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    chk("overrun_set", 64'(overrun), 64'd1);
    drain();
    chk("overrun_sticky", 64'(overrun), 64'd1);
    pulse_clear();
    chk("overrun_cleared", 64'(overrun), 64'd0);

    // Clear coinciding with a new overrun loses to the set.
    send(28'd3, 28'd3, 28'd3, 28'd9, C_SGL, 2'd1, 2'd3, L_DIV, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    valid_in = 1'b1;
    clear = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    clear = 1'b0;
    chk("overrun_set_wins", 64'(overrun), 64'd1);
    drain();
    pulse_clear();
    chk("overrun_cleared2", 64'(overrun), 64'd0);

    // Reset during division aborts it without any result.
    send(28'd5, 28'd10, 28'd5, 28'd15, C_SGL, 2'd2, 2'd3, L_DIV, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("div_busy_not_ready", 64'(ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("abort_err_valid", 64'(err_valid),  64'd0);
    chk("abort_single",    64'(err_single), 64'd0);
    chk("abort_mag",       64'(err_mag),    64'd0);
    chk("abort_row",       64'(err_row),    64'd0);
    chk("abort_ready",     64'(ready),      64'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_ready_after", 64'(ready),     64'd1);
    chk("abort_no_result",   64'(err_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
